// File: rtl/spi_reg_sequencer.sv
// Register-access sequencer behind an SPI byte bridge: decodes a command byte,
// then streams register writes or prefetched register reads, one per data byte.
module spi_reg_sequencer #(
  parameter int REG_COUNT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs_n,
  input  logic       byte_sync,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [5:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       addr_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ACC
  } state_t;

  localparam logic [6:0] ADDR_LIMIT = 7'(REG_COUNT);

  state_t state;
  logic   cmd_rd;
  logic   cmd_inc;
  logic   rd_pend;

  function automatic logic in_range(input logic [5:0] addr);
    return {1'b0, addr} < ADDR_LIMIT;
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: strobes default low every edge so each one lasts exactly one cycle.
    reg_wr   <= 1'b0;
    reg_rd   <= 1'b0;
    addr_err <= 1'b0;

    if (rst) begin
      state     <= IDLE;
      data_out  <= 8'h00;
      reg_addr  <= 6'd0;
      reg_wdata <= 8'h00;
      cmd_rd    <= 1'b0;
      cmd_inc   <= 1'b0;
      rd_pend   <= 1'b0;
    end else if (cs_n) begin
      // Deselect aborts everything not yet issued, from any state.
      state    <= IDLE;
      rd_pend  <= 1'b0;
      data_out <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          data_out <= 8'h00;
          if (byte_sync) begin
            cmd_rd   <= data_in[7];
            cmd_inc  <= data_in[6];
            reg_addr <= data_in[5:0];
            if (data_in[7]) begin
              // Prefetch so the first data byte already shifts out reg[A].
              reg_rd   <= in_range(data_in[5:0]);
              addr_err <= !in_range(data_in[5:0]);
              state    <= ACC;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (rd_pend) begin
            rd_pend  <= 1'b0;
            reg_rd   <= in_range(reg_addr);
            addr_err <= !in_range(reg_addr);
            state    <= ACC;
          end else if (byte_sync) begin
            if (cmd_rd) begin
              if (cmd_inc) reg_addr <= reg_addr + 6'd1;
              rd_pend <= 1'b1;
            end else begin
              reg_wr    <= in_range(reg_addr);
              addr_err  <= !in_range(reg_addr);
              reg_wdata <= data_in;
              state     <= ACC;
            end
          end
        end

        ACC: begin
          if (cmd_rd) begin
            // A suppressed read returns zeros instead of stale bus data.
            data_out <= reg_rd ? reg_rdata : 8'h00;
          end else if (cmd_inc) begin
            reg_addr <= reg_addr + 6'd1;
          end
          state <= DATA;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed bench for spi_reg_sequencer: a full-map instance and an 8-register
// instance share stimulus; expected values are hand-computed per transaction.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       byte_sync;
  logic [7:0] data_in;

  logic [7:0] a_data_out, a_wdata, a_rdata;
  logic [5:0] a_addr;
  logic       a_wr, a_rd, a_err, a_busy;
  logic [7:0] b_data_out, b_wdata, b_rdata;
  logic [5:0] b_addr;
  logic       b_wr, b_rd, b_err, b_busy;

  logic [7:0] regs [64];
  assign a_rdata = regs[a_addr];
  assign b_rdata = regs[b_addr];

  int checks = 0;
  int errors = 0;
  int a_rd_cnt = 0, a_wr_cnt = 0, b_rd_cnt = 0, b_wr_cnt = 0, b_err_cnt = 0;
  int both_cnt = 0;
  int snap_a, snap_b, snap_e;

  always #5 clk = ~clk;

  spi_reg_sequencer #(.REG_COUNT(64)) u_dut64 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync), .data_in(data_in),
    .data_out(a_data_out), .reg_addr(a_addr), .reg_wr(a_wr), .reg_wdata(a_wdata),
    .reg_rd(a_rd), .reg_rdata(a_rdata), .addr_err(a_err), .busy(a_busy)
  );

  spi_reg_sequencer #(.REG_COUNT(8)) u_dut8 (
    .clk(clk), .rst(rst), .cs_n(cs_n), .byte_sync(byte_sync), .data_in(data_in),
    .data_out(b_data_out), .reg_addr(b_addr), .reg_wr(b_wr), .reg_wdata(b_wdata),
    .reg_rd(b_rd), .reg_rdata(b_rdata), .addr_err(b_err), .busy(b_busy)
  );

  always @(posedge clk) begin
    if (a_rd) a_rd_cnt <= a_rd_cnt + 1;
    if (a_wr) a_wr_cnt <= a_wr_cnt + 1;
    if (b_rd) b_rd_cnt <= b_rd_cnt + 1;
    if (b_wr) b_wr_cnt <= b_wr_cnt + 1;
    if (b_err) b_err_cnt <= b_err_cnt + 1;
    if ((a_wr && a_rd) || (b_wr && b_rd)) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge after the sampling posedge, i.e. in cycle T+1.
  task automatic send_byte(input logic [7:0] b, input bit abort);
    @(negedge clk);
    byte_sync = 1'b1;
    data_in   = b;
    @(negedge clk);
    byte_sync = 1'b0;
    if (abort) cs_n = 1'b1;
  endtask

  task automatic new_frame();
    @(negedge clk);
    cs_n = 1'b1;
    gap(2);
    cs_n = 1'b0;
    gap(1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'(i) + 8'h40;
    regs[0]  = 8'h99;
    regs[3]  = 8'h11;
    regs[4]  = 8'h22;
    regs[5]  = 8'h33;
    regs[10] = 8'h5A;

    rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
    gap(3);
    check("rst_data_out", a_data_out, 8'h00);
    check("rst_addr", a_addr, 6'd0);
    check("rst_wdata", a_wdata, 8'h00);
    check("rst_strobes", {a_wr, a_rd, a_err, a_busy}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Single write: 0x05 then 0xA5.
    new_frame();
    snap_a = a_rd_cnt;
    send_byte(8'h05, 1'b0);
    check("wr_cmd_busy", a_busy, 1'b1);
    check("wr_cmd_no_wr", a_wr, 1'b0);
    gap(8);
    send_byte(8'hA5, 1'b0);
    check("wr_strobe", a_wr, 1'b1);
    check("wr_addr", a_addr, 6'd5);
    check("wr_wdata", a_wdata, 8'hA5);
    @(negedge clk);
    check("wr_one_cycle", a_wr, 1'b0);
    check("wr_no_rd", a_rd_cnt - snap_a, 0);

    // Burst read 0xC3 over reg[3..5].
    new_frame();
    snap_a = a_rd_cnt;
    send_byte(8'hC3, 1'b0);
    check("rd_prefetch", a_rd, 1'b1);
    check("rd_prefetch_addr", a_addr, 6'd3);
    @(negedge clk);
    check("rd_data0", a_data_out, 8'h11);
    for (int k = 0; k < 2; k++) begin
      gap(6);
      send_byte(8'h00, 1'b0);
      check("rd_inc_addr", a_addr, 6'(4 + k));
      check("rd_not_yet", a_rd, 1'b0);
      @(negedge clk);
      check("rd_strobe", a_rd, 1'b1);
      @(negedge clk);
      check("rd_data", a_data_out, (k == 0) ? 8'h22 : 8'h33);
    end
    check("rd_count", a_rd_cnt - snap_a, 3);
    new_frame();
    check("idle_data_out", a_data_out, 8'h00);
    check("idle_busy", a_busy, 1'b0);

    // Wrap: write with increment from 63.
    send_byte(8'h7F, 1'b0);
    gap(8);
    send_byte(8'h01, 1'b0);
    check("wrap_addr63", a_addr, 6'd63);
    check("wrap_wdata1", {a_wr, a_wdata}, 9'h101);
    gap(8);
    send_byte(8'h02, 1'b0);
    check("wrap_addr0", a_addr, 6'd0);
    check("wrap_wdata2", {a_wr, a_wdata}, 9'h102);

    // Out of range on the 8-register instance: read 10, then write 9.
    new_frame();
    snap_b = b_rd_cnt; snap_e = b_err_cnt;
    send_byte(8'h8A, 1'b0);
    check("oor_rd_suppressed", b_rd, 1'b0);
    check("oor_rd_err", b_err, 1'b1);
    @(negedge clk);
    check("oor_err_pulse", b_err, 1'b0);
    check("oor_data_out", b_data_out, 8'h00);
    check("oor_in_range_ok", a_data_out, 8'h5A);
    check("oor_err_count", b_err_cnt - snap_e, 1);
    check("oor_rd_count", b_rd_cnt - snap_b, 0);
    new_frame();
    snap_b = b_wr_cnt;
    send_byte(8'h09, 1'b0);
    gap(8);
    send_byte(8'h44, 1'b0);
    check("oor_wr_err", b_err, 1'b1);
    check("oor_wr_full_map", a_wr, 1'b1);
    check("oor_wr_count", b_wr_cnt - snap_b, 0);

    // Abort: cs_n rises one clk after the write data byte.
    new_frame();
    send_byte(8'h12, 1'b0);
    gap(8);
    send_byte(8'h77, 1'b1);
    check("abort_wr_issued", {a_wr, a_addr, a_wdata}, {1'b1, 6'h12, 8'h77});
    @(negedge clk);
    check("abort_busy", a_busy, 1'b0);
    check("abort_wr_done", a_wr, 1'b0);
    cs_n = 1'b0;
    gap(1);
    send_byte(8'h85, 1'b0);
    check("abort_new_cmd", {a_rd, a_addr}, {1'b1, 6'd5});
    @(negedge clk);
    check("abort_new_data", a_data_out, 8'h33);

    // byte_sync ignored while deselected.
    @(negedge clk);
    cs_n = 1'b1;
    gap(2);
    snap_a = a_rd_cnt;
    send_byte(8'h80, 1'b0);
    gap(2);
    check("ignore_busy", a_busy, 1'b0);
    check("ignore_no_rd", a_rd_cnt - snap_a, 0);

    // Reset mid-burst with a prefetch pending.
    cs_n = 1'b0;
    gap(1);
    send_byte(8'hC0, 1'b0);
    @(negedge clk);
    check("rst_burst_data", a_data_out, 8'h99);
    gap(6);
    send_byte(8'h00, 1'b0);
    check("rst_burst_addr", a_addr, 6'd1);
    snap_a = a_rd_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", {a_data_out, 2'b00, a_addr, a_wdata},
          {8'h00, 2'b00, 6'd0, 8'h00});
    check("rst_mid_strobes", {a_wr, a_rd, a_err, a_busy}, 4'b0000);
    rst = 1'b0;
    gap(10);
    check("rst_no_strobes", a_rd_cnt - snap_a, 0);
    check("rst_wait_cmd", a_busy, 1'b0);
    send_byte(8'h82, 1'b0);
    check("rst_new_cmd", {a_rd, a_addr}, {1'b1, 6'd2});

    gap(2);
    check("never_wr_and_rd", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_sequencer.md
SPI_REG_SEQUENCER -- requirements
Module: spi_reg_sequencer

Interface
REQ-001 SHALL have parameter REG_COUNT, default 64, number of implemented registers; legal range 1..64.
REQ-002 SHALL have port clk  input  1  peripheral clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port cs_n  input  1  SPI chip select, active-low; high ends a transaction.
REQ-005 SHALL have port byte_sync  input  1  one-clk pulse, a byte from the SPI bridge is complete.
REQ-006 SHALL have port data_in  input  8  received byte, valid while byte_sync is high.
REQ-007 SHALL have port data_out  output  8  byte the SPI bridge shifts out on MISO during the next byte.
REQ-008 SHALL have port reg_addr  output  6  register address.
REQ-009 SHALL have port reg_wr  output  1  one-clk write strobe.
REQ-010 SHALL have port reg_wdata  output  8  write data, valid while reg_wr is high.
REQ-011 SHALL have port reg_rd  output  1  one-clk read strobe; reg_rdata is valid in the same cycle.
REQ-012 SHALL have port reg_rdata  input  8  combinational read data.
REQ-013 SHALL have port addr_err  output  1  one-clk pulse, an access hit an address >= REG_COUNT.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE (wait for command byte), DATA (data bytes) and ACC (one-cycle register access).
REQ-016 SHALL decode the first byte after cs_n falls as the command: bit7 = 1 read / 0 write, bit6 = auto-increment, bits5:0 = start address.
REQ-017 SHALL, on byte_sync in IDLE with cs_n low, latch the command and go to DATA (write) or ACC (read prefetch) on the next edge.
REQ-018 SHALL, on a write, assert reg_wr for exactly one cycle at T+1 for byte_sync at T, with reg_wdata = data_in captured at T and reg_addr = current address.
REQ-019 SHALL, on a read, assert reg_rd for one cycle with reg_addr = current address, and register reg_rdata into data_out at the end of that cycle.
REQ-020 SHALL, for a read command, prefetch address A in the cycle after the command byte_sync so that data_out holds reg[A] at T+2.
REQ-021 SHALL, for each read data byte_sync at T with auto-increment set, load address A+1 at T+1, assert reg_rd at T+2 and have data_out valid at T+3.
REQ-022 SHALL, with auto-increment clear, leave the address unchanged; repeated bytes re-access the same register.
REQ-023 SHALL compute address increments modulo 64 (63 -> 0), which is 6-bit wrap-around.
REQ-024 SHALL, for an address >= REG_COUNT, suppress reg_wr, suppress reg_rd, load data_out = 0x00 and pulse addr_err in the cycle the access would have occurred.
REQ-025 SHALL hold data_out = 0x00 in IDLE, so the command byte clocks out zeros.
REQ-026 SHALL return to IDLE on the edge after cs_n is sampled high, from any state.
REQ-027 SHALL still issue a reg_wr already due at T+1 when cs_n rises at T+1 (the byte was complete); a prefetch reg_rd not yet issued is cancelled.
REQ-028 SHALL ignore byte_sync while cs_n is high.
REQ-029 SHALL ignore byte_sync arriving in ACC; the bridge guarantees at least 8 clk between byte_sync pulses.
REQ-030 SHALL never assert reg_wr and reg_rd in the same cycle.

Reset
REQ-031 SHALL, while rst is high, force state IDLE, data_out = 0x00, reg_addr = 0, reg_wdata = 0x00, reg_wr = 0, reg_rd = 0, addr_err = 0 and busy = 0.
REQ-032 SHALL, on rst asserted mid-transaction, drop all pending strobes without issuing them, and SHALL wait for a new command byte after release even if cs_n stays low.

Verification
REQ-033 Single write, cs_n low, bytes 0x05 then 0xA5 -> one reg_wr with reg_addr = 5 and reg_wdata = 0xA5 at T+1 of the second byte_sync; no reg_rd.
REQ-034 Burst read, command 0xC3 with reg[3..5] = 0x11, 0x22, 0x33 -> data_out = 0x11, 0x22, 0x33 on successive bytes; three reg_rd pulses at addresses 3, 4, 5.
REQ-035 Wrap: command 0x7F (write, increment, address 63), data 0x01 and 0x02 -> writes at address 63 then 0, with REG_COUNT = 64.
REQ-036 Out of range: REG_COUNT = 8, command 0x8A (read address 10) -> no reg_rd, addr_err pulses once, data_out = 0x00.
REQ-037 Abort: cs_n rises one clk after a write data byte_sync -> that reg_wr still occurs; busy = 0 the next cycle; the next byte after cs_n falls is decoded as a command.
REQ-038 Reset mid-burst: rst is pulsed during a read burst -> all outputs at reset values the next cycle; no strobes are issued until a new command byte.
